vga_bram_reader: RTL and testbench



---
 rtl/vga_bram_reader_if.sv | 24 ++
 rtl/vga_bram_reader.sv | 202 ++++++++++++++++++++
 tb/tb_vga_bram_reader.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_bram_reader_if.sv
// vga_bram_reader_if: read-port bundle between the VGA scan-out block and the
// frame-buffer BRAM. The scanner is the master (drives enable/address, takes
// data back); the BRAM read port is the slave.
`timescale 1ns/1ps

interface vga_bram_reader_if #(
  parameter int PIX_W = 12
);
  logic [PIX_W-1:0] bram_dout;
  logic             bram_read_enable;
  logic [18:0]      bram_address;

  modport master (
    output bram_read_enable,
    output bram_address,
    input  bram_dout
  );

  modport slave (
    input  bram_read_enable,
    input  bram_address,
    output bram_dout
  );
endinterface

// File: rtl/vga_bram_reader.sv
// vga_bram_reader: scans the camera frame buffer in raster order and drives a
// VGA port (default 640x480@60 from a 25 MHz pixel clock). Sync and blanking
// flags travel through a delay line matched to the address register plus the
// BRAM read latency, so pixels, syncs and frame_start leave together,
// RD_LATENCY+2 clocks after the counter state that produced them.
//
// Build option: define VGA_BRAM_SCALE2X_EN for a half-resolution buffer
// (H_ACTIVE/2 x V_ACTIVE/2) shown as 2x2 blocks. Without it the buffer maps
// 1:1 onto the active area.
`timescale 1ns/1ps

module vga_bram_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RD_LATENCY = 1,   // BRAM read latency, 1..3
  parameter int PIX_W      = 12
) (
  input  logic              p_clk,
  input  logic              sysrst_n,
  input  logic              display_enable,
  vga_bram_reader_if.master bram,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_BRAM_SCALE2X_EN
  // One stored row covers two output pixels per address.
  localparam logic [18:0] ROW_STEP = 19'(H_ACTIVE / 2);
`endif

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  // Per-pixel timing flags carried alongside the BRAM read.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic first;
  } flags_t;

  localparam flags_t FLAGS_BLANK = '{active: 1'b0, hs: 1'b1, vs: 1'b1, first: 1'b0};

  state_t        state, state_next;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          scanning;
  logic          h_last;
  logic          frame_wrap;
  flags_t        s0;
  logic [18:0]   next_addr;
  flags_t        flag_pipe [RD_LATENCY+1];
  flags_t        dly;

  assign scanning   = (state != IDLE);
  assign h_last     = (h_cnt == H_LAST);
  assign frame_wrap = h_last && (v_cnt == V_LAST);

  // State register.
  // NOTE: clocked state is always updated with <= so every flop samples the
  // pre-edge values of its neighbours; = here would create order-dependent races.
  always_ff @(posedge p_clk or negedge sysrst_n) begin
    if (!sysrst_n) state <= IDLE;
    else           state <= state_next;
  end

  // Next-state: start on enable, finish the current frame before idling.
  // NOTE: state_next takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (display_enable) state_next = RUN;
      RUN:      if (!display_enable) state_next = STOPPING;
      STOPPING: begin
        if (display_enable)  state_next = RUN;
        else if (frame_wrap) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // Raster counters: held at zero while idle, free-running while scanning.
  always_ff @(posedge p_clk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!scanning) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Stage 0 flags decoded straight from the counters; forced blank when idle.
  always_comb begin
    s0.active = scanning && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    s0.hs     = !(scanning && (h_cnt >= HS_BEG) && (h_cnt < HS_END));
    s0.vs     = !(scanning && (v_cnt >= VS_BEG) && (v_cnt < VS_END));
    s0.first  = scanning && (h_cnt == '0) && (v_cnt == '0);
  end

  // Address generator: next_addr is the next word to fetch; bram_address
  // latches it on each fetch so the port never shows a word past the buffer.
  always_ff @(posedge p_clk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      next_addr             <= '0;
      bram.bram_address     <= '0;
      bram.bram_read_enable <= 1'b0;
    end else begin
      bram.bram_read_enable <= s0.active;
      if (!scanning || frame_wrap) begin
        next_addr         <= '0;
        bram.bram_address <= '0;
      end
`ifdef VGA_BRAM_SCALE2X_EN
      // Fetch on even columns only; odd columns reuse the held address.
      else if (s0.active && !h_cnt[0]) begin
        bram.bram_address <= next_addr;
        next_addr         <= next_addr + 19'd1;
      end
      // After an even line rewind one stored row so the next line repeats
      // it; after an odd line next_addr already points at the next row.
      else if (h_last && (v_cnt < V_ACT) && !v_cnt[0]) begin
        next_addr <= next_addr - ROW_STEP;
      end
`else
      else if (s0.active) begin
        bram.bram_address <= next_addr;
        next_addr         <= next_addr + 19'd1;
      end
`endif
    end
  end

  // Flag delay line matching the address register plus BRAM latency.
  // NOTE: this small array is built from flops and is reset like any other
  // state; only true RAM macros are left unreset.
  always_ff @(posedge p_clk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      for (int i = 0; i <= RD_LATENCY; i++) flag_pipe[i] <= FLAGS_BLANK;
    end else begin
      flag_pipe[0] <= s0;
      for (int i = 1; i <= RD_LATENCY; i++) flag_pipe[i] <= flag_pipe[i-1];
    end
  end

  assign dly = flag_pipe[RD_LATENCY];

  // Output register: pixel data joins its flags; RGB forced to zero in blanking.
  always_ff @(posedge p_clk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_hsync   <= dly.hs;
      vga_vsync   <= dly.vs;
      frame_start <= dly.first;
      if (dly.active) begin
        vga_r <= bram.bram_dout[PIX_W-1 -: 4];
        vga_g <= bram.bram_dout[PIX_W-5 -: 4];
        vga_b <= bram.bram_dout[PIX_W-9 -: 4];
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_bram_reader.sv
// tb_vga_bram_reader: drives two instances (BRAM latency 1 and 3) with a
// reduced raster geometry so whole frames fit in a short run. A reference
// model tracks the scan position per clock from the enable/reset rules and
// predicts every output from raster arithmetic.
`timescale 1ns/1ps

module tb_vga_bram_reader;

  localparam int HA  = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA  = 6,  VFP = 1, VSW = 2, VBP = 2;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FT  = HT * VT;
`ifdef VGA_BRAM_SCALE2X_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif
  localparam int MAX_ADDR = SCALE ? (HA/2)*(VA/2) - 1 : HA*VA - 1;

  logic p_clk = 1'b0;
  logic sysrst_n;
  logic display_enable;

  logic       hs1, vs1, fs1, hs3, vs3, fs3;
  logic [3:0] r1, g1, b1, r3, g3, b3;

  vga_bram_reader_if #(.PIX_W(12)) bus1 ();
  vga_bram_reader_if #(.PIX_W(12)) bus3 ();

  vga_bram_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .RD_LATENCY(1), .PIX_W(12)
  ) dut1 (
    .p_clk(p_clk), .sysrst_n(sysrst_n), .display_enable(display_enable),
    .bram(bus1), .vga_hsync(hs1), .vga_vsync(vs1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .frame_start(fs1)
  );

  vga_bram_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .RD_LATENCY(3), .PIX_W(12)
  ) dut3 (
    .p_clk(p_clk), .sysrst_n(sysrst_n), .display_enable(display_enable),
    .bram(bus3), .vga_hsync(hs3), .vga_vsync(vs3),
    .vga_r(r3), .vga_g(g3), .vga_b(b3), .frame_start(fs3)
  );

  always #20 p_clk = ~p_clk;

  // BRAM models: data word = low 12 bits of the address, after L clocks.
  logic [11:0] mp1;
  logic [11:0] mp3 [3];
  always @(posedge p_clk) begin
    mp1    <= bus1.bram_address[11:0];
    mp3[0] <= bus3.bram_address[11:0];
    mp3[1] <= mp3[0];
    mp3[2] <= mp3[1];
  end
  assign bus1.bram_dout = mp1;
  assign bus3.bram_dout = mp3[2];

  // ---------------------------------------------------------------- checking
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------- reference model
  typedef enum {M_IDLE, M_RUN, M_STOP} mstate_t;
  mstate_t mstate = M_IDLE;
  int      pos    = 0;
  int      hist[$];   // scan position per clock, -1 = not scanning

  function automatic int lookup(int d);
    if (hist.size() > d) return hist[hist.size()-1-d];
    return -1;
  endfunction

  function automatic logic m_active(int p);
    if (p < 0) return 1'b0;
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic logic m_hs(int p);
    int x;
    if (p < 0) return 1'b1;
    x = p % HT;
    return !(x >= HA+HFP && x < HA+HFP+HSW);
  endfunction

  function automatic logic m_vs(int p);
    int y;
    if (p < 0) return 1'b1;
    y = p / HT;
    return !(y >= VA+VFP && y < VA+VFP+VSW);
  endfunction

  function automatic int m_addr(int p);
    int x, y;
    x = p % HT;
    y = p / HT;
    return SCALE ? (y/2)*(HA/2) + x/2 : y*HA + x;
  endfunction

  task automatic model_step();
    if (!sysrst_n) begin
      mstate = M_IDLE;
      pos    = 0;
    end else begin
      case (mstate)
        M_IDLE: if (display_enable) begin mstate = M_RUN; pos = 0; end
        M_RUN: begin
          pos = (pos + 1) % FT;
          if (!display_enable) mstate = M_STOP;
        end
        default: begin
          if (display_enable) begin
            mstate = M_RUN;
            pos    = (pos + 1) % FT;
          end else if (pos == FT-1) begin
            mstate = M_IDLE;
            pos    = 0;
          end else begin
            pos = pos + 1;
          end
        end
      endcase
    end
    hist.push_back(mstate == M_IDLE ? -1 : pos);
  endtask

  task automatic reset_model();
    mstate = M_IDLE;
    pos    = 0;
    repeat (6) hist.push_back(-1);
  endtask

  task automatic compare_dut(input string tag, input int lat, input logic hs, input logic vs,
                             input logic [11:0] rgb, input logic fs, input logic rd_en,
                             input logic [18:0] addr);
    int p = lookup(lat + 2);
    int q = lookup(1);
    logic [11:0] pix = m_active(p) ? 12'(m_addr(p)) : 12'd0;
    check({tag, ".hsync"}, 32'(hs), 32'(m_hs(p)));
    check({tag, ".vsync"}, 32'(vs), 32'(m_vs(p)));
    check({tag, ".rgb"}, 32'(rgb), 32'(pix));
    check({tag, ".frame_start"}, 32'(fs), 32'(p == 0));
    check({tag, ".rd_en"}, 32'(rd_en), 32'(m_active(q)));
    if (q < 0) check({tag, ".addr_idle"}, 32'(addr), 32'd0);
    else if (m_active(q)) check({tag, ".addr"}, 32'(addr), 32'(m_addr(q)));
  endtask

  // Running statistics on the latency-1 instance (plus frame_start on both).
  logic prev_hs1 = 1'b1, prev_vs1 = 1'b1;
  int hs_edges, vs_edges, hs_low, vs_low, rd_cnt, fs_cnt1, fs_cnt3, max_addr;

  task automatic clear_stats();
    hs_edges = 0; vs_edges = 0; hs_low = 0; vs_low = 0;
    rd_cnt = 0; fs_cnt1 = 0; fs_cnt3 = 0; max_addr = 0;
  endtask

  task automatic tick();
    @(posedge p_clk);
    cyc++;
    model_step();
    #1;
  endtask

  task automatic run_cycle();
    tick();
    compare_dut("L1", 1, hs1, vs1, {r1, g1, b1}, fs1, bus1.bram_read_enable, bus1.bram_address);
    compare_dut("L3", 3, hs3, vs3, {r3, g3, b3}, fs3, bus3.bram_read_enable, bus3.bram_address);
    if (prev_hs1 && !hs1) hs_edges++;
    if (prev_vs1 && !vs1) vs_edges++;
    if (!hs1) hs_low++;
    if (!vs1) vs_low++;
    prev_hs1 = hs1;
    prev_vs1 = vs1;
    if (bus1.bram_read_enable) begin
      rd_cnt++;
      if (int'(bus1.bram_address) > max_addr) max_addr = int'(bus1.bram_address);
    end
    if (fs1) fs_cnt1++;
    if (fs3) fs_cnt3++;
  endtask

  task automatic check_vec(input string tag, input logic hs, input logic vs, input logic [11:0] rgb,
                           input logic rd_en, input logic [18:0] addr, input logic fs);
    check({tag, ".L1.hsync"}, 32'(hs1), 32'(hs));
    check({tag, ".L1.vsync"}, 32'(vs1), 32'(vs));
    check({tag, ".L1.rgb"}, 32'({r1, g1, b1}), 32'(rgb));
    check({tag, ".L1.rd_en"}, 32'(bus1.bram_read_enable), 32'(rd_en));
    check({tag, ".L1.addr"}, 32'(bus1.bram_address), 32'(addr));
    check({tag, ".L1.frame_start"}, 32'(fs1), 32'(fs));
    check({tag, ".L3.hsync"}, 32'(hs3), 32'(hs));
    check({tag, ".L3.vsync"}, 32'(vs3), 32'(vs));
    check({tag, ".L3.rgb"}, 32'({r3, g3, b3}), 32'(rgb));
    check({tag, ".L3.rd_en"}, 32'(bus3.bram_read_enable), 32'(rd_en));
    check({tag, ".L3.addr"}, 32'(bus3.bram_address), 32'(addr));
    check({tag, ".L3.frame_start"}, 32'(fs3), 32'(fs));
  endtask

  // ----------------------------------------------------------- vector table
  typedef struct {
    string       name;
    logic        rst_n;
    logic        en;
    int          cycles;
    logic        exp_hs;
    logic        exp_vs;
    logic [11:0] exp_rgb;
    logic        exp_rd_en;
    logic [18:0] exp_addr;
    logic        exp_fs;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k1, k3;

    // reset, idle, first two clocks of RUN (still inside the pipeline), async reset
    vecs[0] = '{"hold_reset",   1'b0, 1'b0, 3,    1'b1, 1'b1, 12'd0, 1'b0, 19'd0, 1'b0};
    vecs[1] = '{"reset_vs_en",  1'b0, 1'b1, 4,    1'b1, 1'b1, 12'd0, 1'b0, 19'd0, 1'b0};
    vecs[2] = '{"idle_1000",    1'b1, 1'b0, 1000, 1'b1, 1'b1, 12'd0, 1'b0, 19'd0, 1'b0};
    vecs[3] = '{"enter_run",    1'b1, 1'b1, 1,    1'b1, 1'b1, 12'd0, 1'b0, 19'd0, 1'b0};
    vecs[4] = '{"first_fetch",  1'b1, 1'b1, 1,    1'b1, 1'b1, 12'd0, 1'b1, 19'd0, 1'b0};
    vecs[5] = '{"async_reset",  1'b0, 1'b0, 0,    1'b1, 1'b1, 12'd0, 1'b0, 19'd0, 1'b0};

    sysrst_n       = 1'b0;
    display_enable = 1'b0;
    #5;
    for (int i = 0; i < 6; i++) begin
      sysrst_n       = vecs[i].rst_n;
      display_enable = vecs[i].en;
      if (!vecs[i].rst_n) reset_model();
      #1;
      repeat (vecs[i].cycles) tick();
      check_vec(vecs[i].name, vecs[i].exp_hs, vecs[i].exp_vs, vecs[i].exp_rgb,
                vecs[i].exp_rd_en, vecs[i].exp_addr, vecs[i].exp_fs);
    end

    // Start-up: first hsync falling edge relative to entering RUN.
    tick();
    sysrst_n       = 1'b1;
    display_enable = 1'b1;
    k1 = -1;
    k3 = -1;
    for (int k = 1; k <= 2*HT; k++) begin
      run_cycle();
      if (k1 < 0 && !hs1) k1 = k;
      if (k3 < 0 && !hs3) k3 = k;
    end
    check("first_hsync_fall.L1", 32'(k1 - 1), 32'(HA + HFP + 1 + 2));
    check("first_hsync_fall.L3", 32'(k3 - 1), 32'(HA + HFP + 3 + 2));

    // One full frame of continuous scanning.
    clear_stats();
    repeat (FT) run_cycle();
    check("frame.read_cycles", 32'(rd_cnt), 32'(HA*VA));
    check("frame.max_addr", 32'(max_addr), 32'(MAX_ADDR));
    check("frame.frame_start.L1", 32'(fs_cnt1), 32'd1);
    check("frame.frame_start.L3", 32'(fs_cnt3), 32'd1);
    check("frame.hsync_pulses", 32'(hs_edges), 32'(VT));
    check("frame.hsync_low", 32'(hs_low), 32'(HSW*VT));
    check("frame.vsync_pulses", 32'(vs_edges), 32'd1);
    check("frame.vsync_low", 32'(vs_low), 32'(VSW*HT));

    // Drop enable at line 3: the frame completes, then the block idles.
    for (int i = 0; i < 2*FT && pos != 3*HT; i++) run_cycle();
    check("reach_line3", 32'(pos), 32'(3*HT));
    display_enable = 1'b0;
    clear_stats();
    for (int i = 0; i < 2*FT && mstate != M_IDLE; i++) run_cycle();
    repeat (8) run_cycle();
    check("stop.vsync_pulses", 32'(vs_edges), 32'd1);
    check("stop.hsync_pulses", 32'(hs_edges), 32'(VT - 3));
    check_vec("stopped_idle", 1'b1, 1'b1, 12'd0, 1'b0, 19'd0, 1'b0);

    // Restart, drop at line 3, re-raise at line 6 of the stopping frame.
    display_enable = 1'b1;
    for (int i = 0; i < 2*FT && !(mstate == M_RUN && pos == 3*HT); i++) run_cycle();
    display_enable = 1'b0;
    clear_stats();
    for (int i = 0; i < 2*FT; i++) begin
      run_cycle();
      if (pos == 6*HT) display_enable = 1'b1;
    end
    check("resume.hsync_pulses", 32'(hs_edges), 32'(2*VT));
    check("resume.frame_start", 32'(fs_cnt1), 32'd2);

    // Mid-frame asynchronous reset, then a clean new frame.
    for (int i = 0; i < 2*FT && pos != 2*HT + 5; i++) run_cycle();
    #3;
    sysrst_n = 1'b0;
    reset_model();
    #1;
    check_vec("midframe_reset", 1'b1, 1'b1, 12'd0, 1'b0, 19'd0, 1'b0);
    repeat (3) run_cycle();
    sysrst_n = 1'b1;
    repeat (2*FT) run_cycle();

    // Randomized enable toggling with occasional resets.
    for (int s = 0; s < 24; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        #3;
        sysrst_n = 1'b0;
        reset_model();
        #1;
        check_vec("rand_reset", 1'b1, 1'b1, 12'd0, 1'b0, 19'd0, 1'b0);
        repeat ($urandom_range(1, 4)) run_cycle();
        sysrst_n = 1'b1;
      end else begin
        display_enable = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 2*FT)) run_cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
